// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and helpers for the pipe_reg pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Largest supported configuration.
    localparam int DEPTH_MAX = 16;
    localparam int DW_MAX    = 1024;

    // Bits needed to count 0..depth occupied stages.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One elastic pipeline stage: a valid/data register pair that
//                loads from upstream whenever it is empty or its downstream
//                neighbour is ready.
//                Optional clear input when PIPE_REG_FLUSH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef PIPE_REG_FLUSH_EN
    input  logic          i_clr,
`endif
    input  logic          i_up_valid,
    input  logic [DW-1:0] i_up_data,
    input  logic          i_dn_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_rdy;

    // A stage can take a new word when empty or when its word moves on.
    assign w_rdy = !r_valid || i_dn_ready;

    // Valid follows upstream when ready; data only loads on a real word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
`ifdef PIPE_REG_FLUSH_EN
        else if (i_clr) begin
            r_valid <= 1'b0;
        end
`endif
        else if (w_rdy) begin
            r_valid <= i_up_valid;
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : DEPTH-deep elastic register pipeline with valid/ready on both
//                sides. Bubbles collapse under backpressure; throughput is one
//                word per cycle. Tracks stage occupancy in a registered count.
//                Macro PIPE_REG_FLUSH_EN adds a synchronous flush input.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DW-1:0]                 in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [DW-1:0]                 out_data,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    // Reject configurations outside the supported range at elaboration.
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_reg: DEPTH out of range 1..16");
    end
    if (DW < 1 || DW > DW_MAX) begin : g_bad_dw
        $error("pipe_reg: DW out of range 1..1024");
    end

    logic [DEPTH:0]           w_rdy;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0][DW-1:0] w_data;
    logic [DEPTH-1:0]         w_up_valid;
    logic [DEPTH-1:0][DW-1:0] w_up_data;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic [CW-1:0]            r_count;

    // The last stage drains into the consumer.
    assign w_rdy[DEPTH] = out_ready;

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_stage
        // Stage k is ready unless it and every stage after it are full while
        // the consumer stalls. Written flat (from registered valids only) so
        // the ready vector has no bit depending on another bit of itself.
        assign w_rdy[k] = out_ready || !(&w_valid[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign w_up_valid[k] = in_valid;
            assign w_up_data[k]  = in_data;
        end else begin : g_body
            assign w_up_valid[k] = w_valid[k-1];
            assign w_up_data[k]  = w_data[k-1];
        end

        pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
`ifdef PIPE_REG_FLUSH_EN
            .i_clr      (flush),
`endif
            .i_up_valid (w_up_valid[k]),
            .i_up_data  (w_up_data[k]),
            .i_dn_ready (w_rdy[k+1]),
            .o_valid    (w_valid[k]),
            .o_data     (w_data[k])
        );
    end

    // Flush blocks both handshakes so nothing fires during the clear.
`ifdef PIPE_REG_FLUSH_EN
    assign in_ready  = w_rdy[0] && !flush;
    assign out_valid = w_valid[DEPTH-1] && !flush;
`else
    assign in_ready  = w_rdy[0];
    assign out_valid = w_valid[DEPTH-1];
`endif
    assign out_data  = w_data[DEPTH-1];

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Occupancy: up on accept only, down on release only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end
`ifdef PIPE_REG_FLUSH_EN
        else if (flush) begin
            r_count <= '0;
        end
`endif
        else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + CW'(1);
        end else if (w_out_fire && !w_in_fire) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipe_reg
//  Description : Self-checking bench for pipe_reg (DW=32, DEPTH=4) with a
//                scoreboard queue of accepted words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] count;
`ifdef PIPE_REG_FLUSH_EN
    logic          flush;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_exp;

    always #5 clk = ~clk;

    pipe_reg #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef PIPE_REG_FLUSH_EN
        .flush     (flush),
`endif
        .out_ready (out_ready),
        .count     (count)
    );

    // Scoreboard: push on input fire, pop/compare on output fire, and
    // check the occupancy count against the number of words in flight.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            checks++;
            if (count !== CW'(sb.size())) begin
                errors++;
                $display("FAIL count_track: count=%0d expected %0d", count, sb.size());
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_spurious: out_data=%h but no word expected", out_data);
                end else begin
                    sb_exp = sb.pop_front();
                    if (out_data !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_order: out_data=%h expected %h", out_data, sb_exp);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb.push_back(in_data);
            end
`ifdef PIPE_REG_FLUSH_EN
            if (flush === 1'b1) begin
                sb.delete();
            end
`endif
        end
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted (bounded).
    task automatic push_one(input logic [DW-1:0] w);
        logic fire;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire === 1'b1) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word %h never accepted", w);
        end
    endtask

    // Let the pipe drain completely (bounded); caller sets out_ready.
    task automatic wait_empty(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && out_valid === 1'b0 && count === '0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: count=%0d pending=%0d expected 0", name, count, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        if (count !== '0)       begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = DW'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready: word %0d got %b expected 1", i, in_ready);
            end
            if (i == 4) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency_early: out_valid=%b expected 0", out_valid);
                end
            end
            if (i == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'h1) begin
                    errors++;
                    $display("FAIL stream_latency: out_valid=%b out_data=%h expected 1/00000001", out_valid, out_data);
                end
            end
            if (i >= 5) begin
                checks++;
                if (count < CW'(3) || count > CW'(4)) begin
                    errors++;
                    $display("FAIL stream_count: got %0d expected 3..4", count);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_empty("stream");
    endtask

    task automatic test_fill_stall();
        int acc;
        int w;
        logic fire;
        acc       = 0;
        w         = 1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(w);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire === 1'b1) begin
                acc++;
                w++;
                in_data = DW'(w);
            end
        end
        checks += 3;
        if (acc != 4)          begin errors++; $display("FAIL fill_accepts: got %0d expected 4", acc); end
        if (count !== CW'(4))  begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 50 && w <= 6; c++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire === 1'b1) begin
                w++;
                in_data = DW'(w);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (w != 7) begin errors++; $display("FAIL fill_resume: pushed %0d words expected 6", w - 1); end
        wait_empty("fill");
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        push_one(32'hA);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        push_one(32'hB);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (count !== CW'(2)) begin errors++; $display("FAIL bubble_count: got %0d expected 2", count); end
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            errors++;
            $display("FAIL bubble_head: out_valid=%b out_data=%h expected 1/0000000a", out_valid, out_data);
        end
        // 0xB must follow immediately, proving it sat in the adjacent stage.
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hB) begin
            errors++;
            $display("FAIL bubble_adjacent: out_valid=%b out_data=%h expected 1/0000000b", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        wait_empty("bubble");
    endtask

    task automatic test_full_fire();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(DW'(32'h20 + i));
        checks++;
        if (count !== CW'(4)) begin errors++; $display("FAIL full_count_pre: got %0d expected 4", count); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = DW'(32'h100 + c);
            @(negedge clk);
            checks += 2;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready: cycle %0d got %b expected 1", c, in_ready); end
            if (count !== CW'(4))  begin errors++; $display("FAIL full_count: cycle %0d got %0d expected 4", c, count); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_empty("full");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(DW'(32'h40 + i));
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL areset_count_pre: got %0d expected 3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        if (count !== '0)       begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_one(32'h55);
        wait_empty("areset");
    endtask

`ifdef PIPE_REG_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(DW'(32'h60 + i));
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL flush_count_pre: got %0d expected 3", count); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks += 2;
        if (count !== '0)       begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid_after: got %b expected 0", out_valid); end
        wait_empty("flush");
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_bubble();
        test_full_fire();
        test_async_reset();
`ifdef PIPE_REG_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
